// File: rtl/micro_seq_pkg.sv
// micro_seq_pkg: sequencer op encodings shared by the Sigma microprogram sequencer
package micro_seq_pkg;
  typedef enum logic [0:2] {
    SEQ_NEXT = 3'd0,
    SEQ_JUMP = 3'd1,
    SEQ_CALL = 3'd2,
    SEQ_RET  = 3'd3,
    SEQ_MAP  = 3'd4,
    SEQ_LDCT = 3'd5,
    SEQ_LOOP = 3'd6,
    SEQ_WAIT = 3'd7
  } seq_op_t;
endpackage

// File: rtl/micro_stack.sv
// micro_stack: return-address LIFO; callers must not push when full or pop when empty
module micro_stack #(
  parameter int ADDR_W = 12,
  parameter int STACK_DEPTH = 4,
  localparam int SP_W = $clog2(STACK_DEPTH + 1),
  localparam int IDX_W = STACK_DEPTH > 1 ? $clog2(STACK_DEPTH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [0:ADDR_W-1] din,
  output logic [0:ADDR_W-1] top,
  output logic [0:SP_W-1]   sp,
  output logic              full,
  output logic              empty
);
  logic [0:ADDR_W-1] mem [STACK_DEPTH];
  logic [0:SP_W-1] sp_dec;
  logic [0:IDX_W-1] wr_idx, rd_idx;
  assign sp_dec = sp - SP_W'(1);
  assign wr_idx = IDX_W'(sp);
  assign rd_idx = IDX_W'(sp_dec);
  assign top = mem[rd_idx];
  assign full = sp == SP_W'(STACK_DEPTH);
  assign empty = sp == '0;
  // contents are deliberately left unreset; only the pointer matters
  always_ff @(posedge clock)
    if (push) mem[wr_idx] <= din;
  always_ff @(posedge clock or negedge reset)
    if (!reset) sp <= '0;
    else if (push) sp <= sp + SP_W'(1);
    else if (pop) sp <= sp_dec;
endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: next control-store address with call stack, loop counter, map dispatch and wait hold
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int CNT_W = 8,
  parameter int STACK_DEPTH = 4,
  parameter int NCOND = 8,
  localparam int SEL_W = $clog2(NCOND),
  localparam int SP_W = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [0:2]        op,
  input  logic [0:ADDR_W-1] din,
  input  logic [0:6]        map_in,
  input  logic [0:NCOND-1]  cond_in,
  input  logic [0:SEL_W-1]  cond_sel,
  input  logic              cond_inv,
  output logic [0:ADDR_W-1] uc_addr,
  output logic [0:ADDR_W-1] cur_addr,
  output logic [0:SP_W-1]   sp,
  output logic              cnt_zero,
  output logic              overflow,
  output logic              underflow
);
  seq_op_t sop;
  logic c, push, pop, full, empty, cnt_nz;
  logic [0:ADDR_W-1] upc, top, nxt;
  logic [0:CNT_W-1] cnt, cnt_nxt;
  assign sop = seq_op_t'(op);
  assign c = cond_in[cond_sel] ^ cond_inv;
  assign cnt_nz = |cnt;
  assign cnt_zero = !cnt_nz;
  always_comb begin
    nxt = upc;
    push = 1'b0;
    pop = 1'b0;
    cnt_nxt = cnt;
    case (sop)
      SEQ_JUMP: nxt = c ? din : upc;
      SEQ_CALL: begin
        nxt = c ? din : upc;
        push = c;
      end
      SEQ_RET: begin
        nxt = !c ? upc : empty ? '0 : top;
        pop = c;
      end
      SEQ_MAP: nxt = ADDR_W'(map_in);
      SEQ_LDCT: cnt_nxt = din[ADDR_W-CNT_W:ADDR_W-1];
      SEQ_LOOP: begin
        nxt = cnt_nz ? din : upc;
        cnt_nxt = cnt_nz ? cnt - CNT_W'(1) : cnt;
      end
      SEQ_WAIT: nxt = c ? upc : cur_addr;
      default: ;
    endcase
  end
  assign uc_addr = reset ? nxt : '0;
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      upc <= '0;
      cur_addr <= '0;
      cnt <= '0;
      overflow <= 1'b0;
      underflow <= 1'b0;
    end else begin
      upc <= uc_addr + ADDR_W'(1);
      cur_addr <= uc_addr;
      cnt <= cnt_nxt;
      overflow <= overflow | (push & full);
      underflow <= underflow | (pop & empty);
    end
  micro_stack #(.ADDR_W(ADDR_W), .STACK_DEPTH(STACK_DEPTH)) u_stack (
    .clock(clock),
    .reset(reset),
    .push(push & ~full),
    .pop(pop & ~empty),
    .din(upc),
    .top(top),
    .sp(sp),
    .full(full),
    .empty(empty)
  );
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed vectors against a queue-based sequencer model plus literal address expectations
module tb_micro_sequencer;
  logic clock, reset, cond_inv, cnt_zero, overflow, underflow;
  logic [0:2] op, cond_sel, sp;
  logic [0:11] din, uc_addr, cur_addr;
  logic [0:6] map_in;
  logic [0:7] cond_in;
  int checks = 0, errors = 0, sel_rot = 0;
  int m_upc = 0, m_cur = 0, m_cnt = 0;
  int stk[$];
  bit m_ovf = 0, m_unf = 0;

  micro_sequencer dut (
    .clock(clock), .reset(reset), .op(op), .din(din), .map_in(map_in),
    .cond_in(cond_in), .cond_sel(cond_sel), .cond_inv(cond_inv),
    .uc_addr(uc_addr), .cur_addr(cur_addr), .sp(sp), .cnt_zero(cnt_zero),
    .overflow(overflow), .underflow(underflow)
  );

  initial clock = 0;
  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int m_c();
    return int'((cond_in >> (7 - int'(cond_sel))) & 8'h01) ^ int'(cond_inv);
  endfunction

  function automatic int f_addr();
    int c;
    c = m_c();
    if (!reset) return 0;
    case (int'(op))
      1, 2: return c ? int'(din) : m_upc;
      3: return !c ? m_upc : (stk.size() > 0 ? stk[$] : 0);
      4: return int'(map_in);
      6: return m_cnt > 0 ? int'(din) : m_upc;
      7: return c ? m_upc : m_cur;
      default: return m_upc;
    endcase
  endfunction

  always @(posedge clock) begin
    int a, c;
    if (!reset) begin
      m_upc = 0; m_cur = 0; m_cnt = 0; stk.delete(); m_ovf = 0; m_unf = 0;
    end else begin
      a = f_addr();
      c = m_c();
      if (op == 3'd2 && c != 0) begin
        if (stk.size() < 4) stk.push_back(m_upc);
        else m_ovf = 1;
      end
      if (op == 3'd3 && c != 0) begin
        if (stk.size() > 0) void'(stk.pop_back());
        else m_unf = 1;
      end
      if (op == 3'd5) m_cnt = int'(din) % 256;
      if (op == 3'd6 && m_cnt > 0) m_cnt = m_cnt - 1;
      m_cur = a;
      m_upc = (a + 1) % 4096;
    end
  end

  always @(negedge clock) begin
    chk("model_uc_addr", uc_addr, f_addr());
    chk("model_cur_addr", cur_addr, m_cur);
    chk("model_sp", sp, stk.size());
    chk("model_cnt_zero", cnt_zero, m_cnt == 0);
    chk("model_overflow", overflow, m_ovf);
    chk("model_underflow", underflow, m_unf);
  end

  // raw is the selected cond_in bit before inversion; the selected bit rotates every call
  task automatic cyc(input int o, input int d, input bit raw, input bit inv, input int exp);
    logic [7:0] m;
    m = 8'h80 >> sel_rot;
    op = 3'(o);
    din = 12'(d);
    cond_sel = 3'(sel_rot);
    cond_in = raw ? m : ~m;
    cond_inv = inv;
    sel_rot = (sel_rot + 3) % 8;
    #1;
    chk("uc_addr", uc_addr, exp);
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset = 0; op = 3'd1; din = 12'h123; cond_in = 8'hFF; cond_sel = 0; cond_inv = 0; map_in = 0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_uc_addr", uc_addr, 0);
    chk("rst_cnt_zero", cnt_zero, 1);
    chk("rst_sp", sp, 0);
    op = 3'd0;
    #1 reset = 1;
    #1 chk("release_uc_addr", uc_addr, 0);
    @(posedge clock);
    #1;
    chk("first_cur", cur_addr, 0);
    chk("first_cnt_zero", cnt_zero, 1);
    cyc(0, 0, 0, 0, 12'h001);
    cyc(0, 0, 1, 0, 12'h002);
    cyc(0, 0, 0, 1, 12'h003);
    cyc(1, 12'h040, 0, 0, 12'h004);
    cyc(1, 12'h040, 1, 0, 12'h040);
    cyc(1, 12'h080, 1, 1, 12'h041);
    cyc(1, 12'h080, 0, 1, 12'h080);
    cyc(3, 0, 0, 0, 12'h081);
    cyc(2, 12'h099, 0, 0, 12'h082);
    chk("call_false_sp", sp, 0);
    cyc(1, 12'h010, 1, 0, 12'h010);
    cyc(2, 12'h020, 1, 0, 12'h020);
    cyc(2, 12'h030, 0, 1, 12'h030);
    cyc(2, 12'h040, 1, 0, 12'h040);
    cyc(2, 12'h050, 1, 0, 12'h050);
    chk("stack_full_sp", sp, 4);
    chk("no_overflow_yet", overflow, 0);
    cyc(2, 12'h060, 1, 0, 12'h060);
    chk("overflow_sp", sp, 4);
    chk("overflow_flag", overflow, 1);
    cyc(3, 0, 1, 0, 12'h041);
    cyc(3, 0, 0, 1, 12'h031);
    cyc(3, 0, 1, 0, 12'h021);
    cyc(3, 0, 1, 0, 12'h011);
    chk("empty_sp", sp, 0);
    chk("no_underflow_yet", underflow, 0);
    cyc(3, 0, 1, 0, 12'h000);
    chk("underflow_flag", underflow, 1);
    chk("overflow_sticky", overflow, 1);
    cyc(1, 12'h100, 1, 0, 12'h100);
    cyc(5, 12'h703, 0, 0, 12'h101);
    chk("ldct_cnt_zero", cnt_zero, 0);
    for (int i = 0; i < 2; i++) begin
      cyc(0, 0, 0, 0, 12'h102);
      cyc(6, 12'h101, i[0], 0, 12'h101);
    end
    cyc(0, 0, 0, 0, 12'h102);
    chk("loop_cnt_nonzero", cnt_zero, 0);
    cyc(6, 12'h101, 1, 0, 12'h101);
    chk("loop_cnt_zero", cnt_zero, 1);
    cyc(0, 0, 0, 0, 12'h102);
    cyc(6, 12'h101, 0, 0, 12'h103);
    cyc(1, 12'h200, 1, 0, 12'h200);
    repeat (5) cyc(7, 0, 0, 0, 12'h200);
    cyc(7, 0, 1, 0, 12'h201);
    cyc(7, 0, 1, 1, 12'h201);
    cyc(7, 0, 0, 1, 12'h202);
    map_in = 7'h32;
    cyc(4, 12'h7FF, 1, 0, 12'h032);
    cyc(0, 0, 0, 0, 12'h033);
    cyc(1, 12'hFFF, 1, 0, 12'hFFF);
    cyc(0, 0, 0, 0, 12'h000);
    cyc(0, 0, 0, 0, 12'h001);
    cyc(6, 12'h555, 1, 0, 12'h002);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
